pdm_seq: RTL and testbench
==========================

Name: pdm_seq

Overview:
- Per-channel slew-limited setpoint sequencer that feeds the PDM modulator's stream input.
- Software writes a target value and step size per channel.
- At every modulator cycle end (str_rdy), each channel's presented value moves one step toward its target, so analog outputs ramp without glitches.
- Sits between the housekeeping register bank and the PDM instance.

Parameters:
- DWC, 8, data/counter width; must match the PDM modulator.
- CHN, 4, number of channels.
- CNW, $clog2(CHN) (minimum 1), channel index width (derived, not overridden).

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- ena  input  1  sequencer enable; tie to the PDM enable
- rng  input  DWC  modulator range; targets are clamped to it
- cfg_we  input  1  configuration write strobe, single cycle
- cfg_chn  input  CNW  channel index for the write
- cfg_tgt  input  DWC  target value
- cfg_stp  input  DWC  step size per modulator cycle; 0 = jump directly to target
- str_dat  output  CHN*DWC  packed per-channel current value, to the PDM str_dat
- str_vld  output  1  valid, to the PDM str_vld
- str_rdy  input  1  PDM cycle-end strobe
- busy  output  CHN  channel not yet at its target
- done  output  1  one-cycle pulse when the last busy channel reaches its target

Behaviour:
- Reset (async assert): clears all cur, tgt and stp registers; str_vld=0, busy=0, done=0. Deassertion is synchronous to clk by external synchroniser.
- Write: on cfg_we, tgt[cfg_chn] <= min(cfg_tgt, rng) and stp[cfg_chn] <= cfg_stp, registered next edge.
  - cfg_chn >= CHN: write ignored.
  - Write accepted regardless of ena.
- Per-channel state from cur vs tgt: HOLD (cur==tgt), UP (cur<tgt), DN (cur>tgt). Evaluated combinationally from registers; busy[i] = state!=HOLD.
- Update: when ena & str_rdy, every channel updates in the same cycle.
  - UP: cur <= (tgt-cur <= stp || stp==0) ? tgt : cur+stp.
  - DN: same rule mirrored, using cur-stp.
  - HOLD: no change.
  - Differences computed at DWC+1 bits; no wrap-around possible; cur never overshoots tgt.
- Same-cycle write and str_rdy on one channel: update uses the old tgt/stp; the new values apply from the next str_rdy.
- rng decreased below an existing tgt: tgt is not re-clamped; software must rewrite it.
- ena=0: str_vld=0, cur holds its value (no reset), busy still reflects cur vs tgt. ena=1: str_vld=1.
- str_dat is driven directly from the cur registers, so it is stable between str_rdy strobes.
- done: registered pulse when |busy goes 1->0 on an update edge.
  - Not asserted for writes that leave the channel already at target.
- Latency: a write is visible in busy 1 cycle later. The first str_dat change happens on the first str_rdy after the write, and is visible the cycle after that strobe.

Optional Feature:
- Macro: PDM_SEQ_IRQ_EN.
- Defined: adds output irq (1 bit) and input irq_clr (1 bit).
  - irq is sticky, set by done.
  - irq is cleared by irq_clr or by any cfg_we.
  - Set wins over clear in the same cycle.
  - Reset value 0.
- Undefined: no irq/irq_clr ports, no extra flops; all other behaviour identical.

Decomposition:
- Package pdm_pkg:
  - typedef enum logic [1:0] {HOLD, UP, DN} pdm_seq_st_t.
  - Localparam PDM_DWC_DEF=8.
  - Function slew_step(cur, tgt, stp) returning the next value.
- Sub-module pdm_seq_chn: one channel's tgt/stp/cur registers plus step logic, instantiated CHN times in a generate loop.
- Top level holds the write decode, the done/irq logic and the packing of str_dat.

Test Plan:
- Reset, then rng=200, write ch0 tgt=100 stp=30, ena=1, strobe str_rdy -> ch0 cur sequence 30, 60, 90, 100; busy[0] drops after the 4th strobe; done pulses once.
- Write ch1 tgt=250 with rng=200 -> tgt clamps to 200; with stp=0 cur jumps to 200 on the first strobe.
- ch2 cur=100, write tgt=10 stp=40 -> cur 60, 20, 10 (DN, no undershoot); str_dat[2] updates only on strobe edges.
- Write ch0 tgt=50 in the same cycle as str_rdy while ramping with old tgt=100 stp=30, cur=30 -> cur becomes 60 (old target), then 50 on the next strobe.
- ena=0 mid-ramp -> str_vld=0 and cur frozen; ena=1 resumes from the frozen value. Async rst asserted between edges -> all outputs 0 immediately.
- With PDM_SEQ_IRQ_EN: done sets irq; irq_clr in the same cycle as done leaves irq=1; a following cfg_we clears it.

Source files
------------

// File: rtl/pdm_pkg.sv
// pdm_pkg: shared types and the slew step helper for the PDM setpoint sequencer.
//   pdm_seq_st_t : per-channel ramp direction (HOLD / UP / DN)
//   PDM_DWC_DEF  : default data width, matches the PDM modulator default
//   slew_step()  : next presented value, moving one step from cur toward tgt
package pdm_pkg;

    localparam int unsigned PDM_DWC_DEF = 8;
    // slew_step works on a fixed wide word so it serves any DWC up to this width.
    localparam int unsigned PDM_DW_MAX  = 32;

    typedef enum logic [1:0] {HOLD, UP, DN} pdm_seq_st_t;

    typedef logic [PDM_DW_MAX-1:0] pdm_word_t;

    // Differences are taken one bit wider than the operands, so neither the
    // distance nor the stepped value can wrap, and the result never passes tgt.
    function automatic pdm_word_t slew_step(input pdm_word_t cur,
                                            input pdm_word_t tgt,
                                            input pdm_word_t stp);
        logic [PDM_DW_MAX:0] dif;
        pdm_word_t           nxt;
        nxt = cur;
        dif = '0;
        if (cur < tgt) begin
            dif = {1'b0, tgt} - {1'b0, cur};
            if ((stp == '0) || (dif <= {1'b0, stp})) begin
                nxt = tgt;
            end else begin
                nxt = cur + stp;
            end
        end else if (cur > tgt) begin
            dif = {1'b0, cur} - {1'b0, tgt};
            if ((stp == '0) || (dif <= {1'b0, stp})) begin
                nxt = tgt;
            end else begin
                nxt = cur - stp;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pdm_seq_chn.sv
// pdm_seq_chn: one sequencer channel (target, step and current-value registers).
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   rng             modulator range; written targets are clamped to it
//   we              write strobe for this channel
//   wr_tgt, wr_stp  target / step to be written
//   upd             update strobe (enable and modulator cycle end)
//   cur             presented value, straight from the register
//   busy            cur differs from the target
//   busy_nxt        cur differs from the target after this edge
// DWC must not exceed pdm_pkg::PDM_DW_MAX.
module pdm_seq_chn
    import pdm_pkg::*;
#(
    parameter int unsigned DWC = PDM_DWC_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [DWC-1:0] rng,
    input  logic           we,
    input  logic [DWC-1:0] wr_tgt,
    input  logic [DWC-1:0] wr_stp,
    input  logic           upd,
    output logic [DWC-1:0] cur,
    output logic           busy,
    output logic           busy_nxt
);

    logic [DWC-1:0] tgt_q, tgt_d;
    logic [DWC-1:0] stp_q, stp_d;
    logic [DWC-1:0] cur_q, cur_d;
    pdm_seq_st_t    st;

    always_comb begin
        if (cur_q == tgt_q) begin
            st = HOLD;
        end else if (cur_q < tgt_q) begin
            st = UP;
        end else begin
            st = DN;
        end
    end

    assign busy = (st != HOLD);

    always_comb begin
        tgt_d = tgt_q;
        stp_d = stp_q;
        if (we) begin
            tgt_d = (wr_tgt > rng) ? rng : wr_tgt;
            stp_d = wr_stp;
        end
    end

    // The update reads the registered tgt/stp, so a write in the same cycle
    // only takes effect from the following strobe.
    always_comb begin
        cur_d = cur_q;
        if (upd && (st != HOLD)) begin
            cur_d = DWC'(slew_step(PDM_DW_MAX'(cur_q), PDM_DW_MAX'(tgt_q),
                                   PDM_DW_MAX'(stp_q)));
        end
    end

    assign busy_nxt = (cur_d != tgt_d);
    assign cur      = cur_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt_q <= '0;
            stp_q <= '0;
            cur_q <= '0;
        end else begin
            tgt_q <= tgt_d;
            stp_q <= stp_d;
            cur_q <= cur_d;
        end
    end

endmodule

// File: rtl/pdm_seq.sv
// pdm_seq: per-channel slew-limited setpoint sequencer feeding a PDM modulator.
// Each channel's presented value moves one step toward its target on every
// modulator cycle end (str_rdy) while enabled.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   ena                        sequencer enable (tied to the PDM enable)
//   rng                        modulator range; targets are clamped to it
//   cfg_we/chn/tgt/stp         single-cycle configuration write
//   str_dat, str_vld, str_rdy  stream interface to the PDM modulator
//   busy                       per-channel not-at-target flags
//   done                       one-cycle pulse when the last busy channel settles
// Optional: define PDM_SEQ_IRQ_EN to add a sticky irq output and irq_clr input.
module pdm_seq
    import pdm_pkg::*;
#(
    parameter int unsigned  DWC = PDM_DWC_DEF,
    parameter int unsigned  CHN = 4,
    localparam int unsigned CNW = (CHN > 1) ? $clog2(CHN) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic [DWC-1:0]     rng,
    input  logic               cfg_we,
    input  logic [CNW-1:0]     cfg_chn,
    input  logic [DWC-1:0]     cfg_tgt,
    input  logic [DWC-1:0]     cfg_stp,
    output logic [CHN*DWC-1:0] str_dat,
    output logic               str_vld,
    input  logic               str_rdy,
    output logic [CHN-1:0]     busy,
`ifdef PDM_SEQ_IRQ_EN
    output logic               irq,
    input  logic               irq_clr,
`endif
    output logic               done
);

    logic [CHN-1:0] we_vec;
    logic [CHN-1:0] busy_nxt;
    logic           upd;
    logic           done_q, done_d;

    // Indices with no matching channel (cfg_chn >= CHN) select nothing.
    always_comb begin
        we_vec = '0;
        for (int i = 0; i < CHN; i++) begin
            if (cfg_we && (cfg_chn == CNW'(i))) begin
                we_vec[i] = 1'b1;
            end
        end
    end

    assign upd = ena & str_rdy;

    for (genvar g = 0; g < CHN; g++) begin : g_chn
        pdm_seq_chn #(
            .DWC (DWC)
        ) u_chn (
            .clk      (clk),
            .rst      (rst),
            .rng      (rng),
            .we       (we_vec[g]),
            .wr_tgt   (cfg_tgt),
            .wr_stp   (cfg_stp),
            .upd      (upd),
            .cur      (str_dat[g*DWC +: DWC]),
            .busy     (busy[g]),
            .busy_nxt (busy_nxt[g])
        );
    end

    // Only an update edge that clears the last busy channel counts; a write
    // that leaves a channel already at target never raises done.
    assign done_d = upd & (|busy) & ~(|busy_nxt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    assign done    = done_q;
    assign str_vld = ena & ~rst;

`ifdef PDM_SEQ_IRQ_EN
    logic irq_q, irq_d;

    // Set by done has priority over any clear in the same cycle.
    always_comb begin
        irq_d = irq_q;
        if (done_q) begin
            irq_d = 1'b1;
        end else if (irq_clr || cfg_we) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_pdm_seq.sv
// tb_pdm_seq: directed, table-driven bench for pdm_seq (DWC=8, CHN=3, rng=200).
// Build with PDM_SEQ_IRQ_EN defined to include the irq sequence as well.
module tb_pdm_seq;

    localparam int unsigned DWC = 8;
    localparam int unsigned CHN = 3;
    localparam int unsigned CNW = 2;

    logic               clk;
    logic               rst;
    logic               ena;
    logic [DWC-1:0]     rng;
    logic               cfg_we;
    logic [CNW-1:0]     cfg_chn;
    logic [DWC-1:0]     cfg_tgt;
    logic [DWC-1:0]     cfg_stp;
    logic [CHN*DWC-1:0] str_dat;
    logic               str_vld;
    logic               str_rdy;
    logic [CHN-1:0]     busy;
    logic               done;
`ifdef PDM_SEQ_IRQ_EN
    logic               irq;
    logic               irq_clr;
`endif

    int n_chk;
    int n_err;

    pdm_seq #(
        .DWC (DWC),
        .CHN (CHN)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .rng     (rng),
        .cfg_we  (cfg_we),
        .cfg_chn (cfg_chn),
        .cfg_tgt (cfg_tgt),
        .cfg_stp (cfg_stp),
        .str_dat (str_dat),
        .str_vld (str_vld),
        .str_rdy (str_rdy),
        .busy    (busy),
`ifdef PDM_SEQ_IRQ_EN
        .irq     (irq),
        .irq_clr (irq_clr),
`endif
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ena;
        logic       we;
        logic [1:0] chn;
        logic [7:0] tgt;
        logic [7:0] stp;
        logic       rdy;
        logic [7:0] e0;
        logic [7:0] e1;
        logic [7:0] e2;
        logic [2:0] ebusy;
        logic       edone;
    } vec_t;

    vec_t vec_q[$];

    task automatic add(input logic ena_v, input logic we_v, input logic [1:0] chn_v,
                       input logic [7:0] tgt_v, input logic [7:0] stp_v, input logic rdy_v,
                       input logic [7:0] e0_v, input logic [7:0] e1_v, input logic [7:0] e2_v,
                       input logic [2:0] eb_v, input logic ed_v);
        vec_t v;
        v.ena = ena_v; v.we = we_v; v.chn = chn_v; v.tgt = tgt_v; v.stp = stp_v;
        v.rdy = rdy_v; v.e0 = e0_v; v.e1 = e1_v; v.e2 = e2_v; v.ebusy = eb_v;
        v.edone = ed_v;
        vec_q.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic idle_inputs();
        cfg_we  = 1'b0;
        cfg_chn = '0;
        cfg_tgt = '0;
        cfg_stp = '0;
        str_rdy = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst   = 1'b1;
        ena   = 1'b0;
        rng   = 8'd200;
        idle_inputs();
`ifdef PDM_SEQ_IRQ_EN
        irq_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset str_dat", 32'(str_dat), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset str_vld", 32'(str_vld), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        //   ena we chn tgt  stp  rdy  c0   c1   c2  busy   done
        add(1, 1, 0, 100, 30, 0,   0,   0,   0, 3'b001, 0); // ch0 ramp setup
        add(1, 0, 0,   0,  0, 1,  30,   0,   0, 3'b001, 0);
        add(1, 0, 0,   0,  0, 0,  30,   0,   0, 3'b001, 0); // stable between strobes
        add(1, 0, 0,   0,  0, 1,  60,   0,   0, 3'b001, 0);
        add(1, 0, 0,   0,  0, 1,  90,   0,   0, 3'b001, 0);
        add(1, 0, 0,   0,  0, 1, 100,   0,   0, 3'b000, 1); // lands on target
        add(1, 0, 0,   0,  0, 0, 100,   0,   0, 3'b000, 0); // done is one cycle
        add(1, 1, 1, 250,  0, 0, 100,   0,   0, 3'b010, 0); // clamp 250 -> 200
        add(1, 0, 0,   0,  0, 1, 100, 200,   0, 3'b000, 1); // stp=0 jumps
        add(1, 1, 2, 100,  0, 0, 100, 200,   0, 3'b100, 0);
        add(1, 0, 0,   0,  0, 1, 100, 200, 100, 3'b000, 1);
        add(1, 1, 2,  10, 40, 0, 100, 200, 100, 3'b100, 0); // ch2 ramp down
        add(1, 0, 0,   0,  0, 0, 100, 200, 100, 3'b100, 0);
        add(1, 0, 0,   0,  0, 1, 100, 200,  60, 3'b100, 0);
        add(1, 0, 0,   0,  0, 1, 100, 200,  20, 3'b100, 0);
        add(1, 0, 0,   0,  0, 1, 100, 200,  10, 3'b000, 1); // no undershoot
        add(1, 1, 0,   0,  0, 0, 100, 200,  10, 3'b001, 0);
        add(1, 0, 0,   0,  0, 1,   0, 200,  10, 3'b000, 1);
        add(1, 1, 0, 100, 30, 0,   0, 200,  10, 3'b001, 0);
        add(1, 0, 0,   0,  0, 1,  30, 200,  10, 3'b001, 0);
        add(1, 1, 0,  50, 30, 1,  60, 200,  10, 3'b001, 0); // write+strobe: old tgt
        add(1, 0, 0,   0,  0, 1,  50, 200,  10, 3'b000, 1); // then new tgt
        add(1, 1, 0, 100, 30, 0,  50, 200,  10, 3'b001, 0);
        add(1, 0, 0,   0,  0, 1,  80, 200,  10, 3'b001, 0);
        add(0, 0, 0,   0,  0, 1,  80, 200,  10, 3'b001, 0); // disabled: frozen
        add(0, 0, 0,   0,  0, 1,  80, 200,  10, 3'b001, 0);
        add(1, 0, 0,   0,  0, 1, 100, 200,  10, 3'b000, 1); // resumes from 80
        add(1, 1, 3,  77,  0, 0, 100, 200,  10, 3'b000, 0); // chn 3 ignored
        add(1, 0, 0,   0,  0, 1, 100, 200,  10, 3'b000, 0);

        for (int i = 0; i < vec_q.size(); i++) begin
            @(negedge clk);
            ena     = vec_q[i].ena;
            cfg_we  = vec_q[i].we;
            cfg_chn = vec_q[i].chn;
            cfg_tgt = vec_q[i].tgt;
            cfg_stp = vec_q[i].stp;
            str_rdy = vec_q[i].rdy;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d str_dat", i), 32'(str_dat),
                {8'd0, vec_q[i].e2, vec_q[i].e1, vec_q[i].e0});
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(vec_q[i].ebusy));
            chk($sformatf("v%0d done", i), 32'(done), 32'(vec_q[i].edone));
            chk($sformatf("v%0d str_vld", i), 32'(str_vld), 32'(vec_q[i].ena));
        end

        // Async reset asserted between edges while done is high.
        @(negedge clk);
        idle_inputs();
        cfg_we  = 1'b1;
        cfg_chn = 2'd0;
        cfg_tgt = 8'd5;
        cfg_stp = 8'd0;
        @(negedge clk);
        idle_inputs();
        str_rdy = 1'b1;
        @(posedge clk);
        #1;
        chk("pre-reset done", 32'(done), 32'd1);
        chk("pre-reset str_dat", 32'(str_dat), {8'd0, 8'd10, 8'd200, 8'd5});
        #2;
        rst = 1'b1;
        #1;
        chk("async reset str_dat", 32'(str_dat), 32'd0);
        chk("async reset busy", 32'(busy), 32'd0);
        chk("async reset done", 32'(done), 32'd0);
        chk("async reset str_vld", 32'(str_vld), 32'd0);
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;

`ifdef PDM_SEQ_IRQ_EN
        @(negedge clk);
        cfg_we  = 1'b1;
        cfg_chn = 2'd0;
        cfg_tgt = 8'd10;
        @(negedge clk);
        idle_inputs();
        str_rdy = 1'b1;
        @(posedge clk);
        #1;
        chk("irq done pulse", 32'(done), 32'd1);
        chk("irq before set", 32'(irq), 32'd0);
        @(negedge clk);
        str_rdy = 1'b0;
        irq_clr = 1'b1;
        @(posedge clk);
        #1;
        chk("irq set wins over clr", 32'(irq), 32'd1);
        @(negedge clk);
        irq_clr = 1'b0;
        cfg_we  = 1'b1;
        cfg_chn = 2'd0;
        cfg_tgt = 8'd10;
        @(posedge clk);
        #1;
        chk("irq cleared by cfg_we", 32'(irq), 32'd0);
        chk("irq no done on at-target write", 32'(done), 32'd0);
        @(negedge clk);
        idle_inputs();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
